i2c_bus_scheduler: RTL and testbench

// Shares one i2c_master among NUM_REQ requesters (elbow angle read, status read, hand

---
 rtl/i2c_bus_scheduler_if.sv | 39 +++
 rtl/i2c_bus_scheduler.sv | 154 +++++++++++++++
 tb/tb_i2c_bus_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_scheduler_if.sv
// Requester-side and i2c_master-side signals of the shared I2C bus scheduler.
// The scheduler uses the master modport; the requesters and i2c_master see the slave side.
interface i2c_bus_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0][6:0]   req_device_id;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ-1:0][31:0]  req_data_wr;
    logic [NUM_REQ-1:0][7:0]   req_number_of_bytes;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [31:0]               rd_data;
    logic                      err;
    logic                      timeout;
    logic                      i2c_ena;
    logic [6:0]                i2c_addr;
    logic                      i2c_rw;
    logic [31:0]               i2c_data_wr;
    logic [7:0]                i2c_number_of_bytes;
    logic                      i2c_busy;
    logic [7:0]                i2c_byte_counter;
    logic [31:0]               i2c_data_rd;
    logic                      i2c_ack_error;

    modport master (
        input  req, req_device_id, req_rw, req_data_wr, req_number_of_bytes,
        input  i2c_busy, i2c_byte_counter, i2c_data_rd, i2c_ack_error,
        output grant, done, rd_data, err, timeout,
        output i2c_ena, i2c_addr, i2c_rw, i2c_data_wr, i2c_number_of_bytes
    );

    modport slave (
        output req, req_device_id, req_rw, req_data_wr, req_number_of_bytes,
        output i2c_busy, i2c_byte_counter, i2c_data_rd, i2c_ack_error,
        input  grant, done, rd_data, err, timeout,
        input  i2c_ena, i2c_addr, i2c_rw, i2c_data_wr, i2c_number_of_bytes
    );
endinterface

// File: rtl/i2c_bus_scheduler.sv
// Round-robin scheduler sharing one i2c_master among NUM_REQ requesters, with an
// inter-transaction idle gap and a grant-to-completion watchdog.
module i2c_bus_scheduler_lane (
    input  logic        sel,
    input  logic [6:0]  addr,
    input  logic        rw,
    input  logic [31:0] data_wr,
    input  logic [7:0]  nbytes,
    output logic [47:0] fld
);
    assign fld = sel ? {addr, rw, data_wr, nbytes} : 48'd0;
endmodule

module i2c_bus_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic             clock,
    input logic             reset_n,
    i2c_bus_scheduler_if.master bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
    localparam logic [GAP_W-1:0]   GAP_LIM = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0]    WD_LIM  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RUN, WAIT_IDLE, COMPLETE, GAP} state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic        rw;
        logic [31:0] data_wr;
        logic [7:0]  nbytes;
    } req_fld_t;

    state_t             state;
    logic [NUM_REQ-1:0] ptr;      // one-hot: highest-priority requester
    logic [NUM_REQ-1:0] owner;    // one-hot: requester owning the bus
    logic [NUM_REQ-1:0] ptr_nxt;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic [47:0]        fld_or [NUM_REQ+1];
    req_fld_t           sel;
    logic [7:0]         nb_eff;

    // Lowest set bit at or above ptr, else lowest set bit overall (wrap).
    assign masked = bus.req & ~(ptr - ONE);
    assign pick   = (masked != '0) ? (masked & (~masked + ONE))
                                   : (bus.req & (~bus.req + ONE));

    assign fld_or[0] = '0;
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
            logic [47:0] lane_fld;
            i2c_bus_scheduler_lane u_lane (
                .sel     (pick[i]),
                .addr    (bus.req_device_id[i]),
                .rw      (bus.req_rw[i]),
                .data_wr (bus.req_data_wr[i]),
                .nbytes  (bus.req_number_of_bytes[i]),
                .fld     (lane_fld)
            );
            assign fld_or[i+1] = fld_or[i] | lane_fld;
        end
        if (NUM_REQ == 1) begin : g_ptr1
            assign ptr_nxt = owner;
        end else begin : g_ptrn
            assign ptr_nxt = {owner[NUM_REQ-2:0], owner[NUM_REQ-1]};
        end
    endgenerate

    assign sel    = req_fld_t'(fld_or[NUM_REQ]);
    assign nb_eff = (sel.nbytes == 8'd0) ? 8'd1 : sel.nbytes;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            ptr                     <= ONE;
            owner                   <= '0;
            gap_cnt                 <= '0;
            wd_cnt                  <= '0;
            bus.grant               <= '0;
            bus.done                <= '0;
            bus.rd_data             <= '0;
            bus.err                 <= 1'b0;
            bus.timeout             <= 1'b0;
            bus.i2c_ena             <= 1'b0;
            bus.i2c_addr            <= '0;
            bus.i2c_rw              <= 1'b0;
            bus.i2c_data_wr         <= '0;
            bus.i2c_number_of_bytes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != '0) begin
                        owner                   <= pick;
                        bus.grant               <= pick;
                        bus.i2c_addr            <= sel.addr;
                        bus.i2c_rw              <= sel.rw;
                        bus.i2c_data_wr         <= sel.data_wr;
                        bus.i2c_number_of_bytes <= nb_eff;
                        bus.i2c_ena             <= 1'b1;
                        bus.err                 <= 1'b0;
                        bus.timeout             <= 1'b0;
                        wd_cnt                  <= '0;
                        state                   <= RUN;
                    end
                end
                RUN, WAIT_IDLE: begin
                    bus.err <= bus.err | bus.i2c_ack_error;
                    if (wd_cnt == WD_LIM) begin
                        // Watchdog abort still completes the handshake so the owner sees done.
                        bus.i2c_ena <= 1'b0;
                        bus.timeout <= 1'b1;
                        bus.err     <= 1'b1;
                        bus.grant   <= '0;
                        bus.done    <= owner;
                        bus.rd_data <= bus.i2c_data_rd;
                        state       <= COMPLETE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (state == RUN) begin
                            if (bus.i2c_byte_counter >= bus.i2c_number_of_bytes) begin
                                bus.i2c_ena <= 1'b0;
                                state       <= WAIT_IDLE;
                            end
                        end else if (!bus.i2c_busy) begin
                            bus.grant   <= '0;
                            bus.done    <= owner;
                            bus.rd_data <= bus.i2c_data_rd;
                            state       <= COMPLETE;
                        end
                    end
                end
                COMPLETE: begin
                    bus.done <= '0;
                    ptr      <= ptr_nxt;
                    owner    <= '0;
                    gap_cnt  <= '0;
                    state    <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LIM) state <= IDLE;
                    else                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed bench for i2c_bus_scheduler: the bench plays requesters and a simple i2c_master.
module tb_i2c_bus_scheduler;
    localparam int N = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    i2c_bus_scheduler_if #(.NUM_REQ(N)) bus ();

    i2c_bus_scheduler #(.NUM_REQ(N), .GAP_CYCLES(100), .TIMEOUT_CYCLES(500)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_grant(output int c);
        c = 0;
        while (bus.grant == '0 && c < 2000) begin
            tick(1);
            c++;
        end
        chk("grant_seen", 32'(bus.grant != '0), 32'd1);
    endtask

    // i2c_master model: one byte every 4 clocks, optional ack_error pulse on byte ack_at.
    task automatic serve(input int nbytes, input logic [31:0] rd, input int ack_at);
        bus.i2c_busy    = 1'b1;
        bus.i2c_data_rd = rd;
        for (int b = 1; b <= nbytes; b++) begin
            tick(3);
            if (b == ack_at) bus.i2c_ack_error = 1'b1;
            tick(1);
            bus.i2c_ack_error = 1'b0;
            if (b == nbytes) chk("ena_hold", 32'(bus.i2c_ena), 32'd1);
            bus.i2c_byte_counter = 8'(b);
        end
        tick(1);
        chk("ena_drop", 32'(bus.i2c_ena), 32'd0);
        tick(2);
        bus.i2c_busy         = 1'b0;
        bus.i2c_byte_counter = 8'd0;
    endtask

    initial begin
        bus.req                 = '0;
        bus.req_device_id       = '0;
        bus.req_rw              = '0;
        bus.req_data_wr         = '0;
        bus.req_number_of_bytes = '0;
        bus.i2c_busy            = 1'b0;
        bus.i2c_byte_counter    = 8'd0;
        bus.i2c_data_rd         = 32'd0;
        bus.i2c_ack_error       = 1'b0;

        // Reset state
        tick(2);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ena", 32'(bus.i2c_ena), 32'd0);
        chk("rst_err", 32'({bus.err, bus.timeout}), 32'd0);
        chk("rst_rd", bus.rd_data, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Single read by requester 0
        bus.req_device_id[0]       = 7'h0C;
        bus.req_rw[0]              = 1'b1;
        bus.req_number_of_bytes[0] = 8'd3;
        bus.req                    = 4'b0001;
        tick(1);
        chk("t1_grant", 32'(bus.grant), 32'h1);
        chk("t1_ena", 32'(bus.i2c_ena), 32'd1);
        chk("t1_addr", 32'(bus.i2c_addr), 32'h0C);
        chk("t1_rw_nb", 32'({bus.i2c_rw, bus.i2c_number_of_bytes}), 32'h103);
        bus.req              = 4'b0000;
        bus.req_device_id[0] = 7'h55;
        serve(3, 32'h0ABC0000, 0);
        tick(1);
        chk("t1_done", 32'(bus.done), 32'h1);
        chk("t1_grant_off", 32'(bus.grant), 32'd0);
        chk("t1_rd", bus.rd_data, 32'h0ABC0000);
        chk("t1_err", 32'({bus.err, bus.timeout}), 32'd0);
        chk("t1_addr_latched", 32'(bus.i2c_addr), 32'h0C);
        tick(1);
        chk("t1_done_pulse", 32'(bus.done), 32'd0);

        // Reset in the middle of a transaction
        bus.req_device_id[1] = 7'h21;
        bus.req              = 4'b0010;
        wait_grant(cyc);
        chk("t5_grant", 32'(bus.grant), 32'h2);
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("t5_ena", 32'(bus.i2c_ena), 32'd0);
        chk("t5_grant_off", 32'(bus.grant), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        bus.req = 4'b0000;
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // All four held: strict rotation from requester 0 with idle gaps
        bus.req_device_id[0] = 7'h10;
        bus.req_device_id[1] = 7'h11;
        bus.req_device_id[2] = 7'h12;
        bus.req_device_id[3] = 7'h13;
        bus.req_rw                 = 4'b0000;
        bus.req_number_of_bytes[0] = 8'd1;
        bus.req_number_of_bytes[1] = 8'd1;
        bus.req_number_of_bytes[2] = 8'd1;
        bus.req_number_of_bytes[3] = 8'd1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(cyc);
            chk("rr_grant", 32'(bus.grant), 32'(1 << (k % 4)));
            chk("rr_addr", 32'(bus.i2c_addr), 32'(16 + (k % 4)));
            if (k > 0) chk("rr_gap", 32'((cyc - 1) >= 100), 32'd1);
            serve(1, 32'd0, 0);
            tick(1);
            chk("rr_done", 32'(bus.done), 32'(1 << (k % 4)));
            if (k == 4) bus.req = 4'b0000;
        end

        // Write with ack error mid-transfer
        bus.req_device_id[2]       = 7'h22;
        bus.req_data_wr[2]         = 32'hDEADBEEF;
        bus.req_number_of_bytes[2] = 8'd4;
        bus.req                    = 4'b0100;
        wait_grant(cyc);
        chk("t3_grant", 32'(bus.grant), 32'h4);
        chk("t3_data", bus.i2c_data_wr, 32'hDEADBEEF);
        chk("t3_rw_nb", 32'({bus.i2c_rw, bus.i2c_number_of_bytes}), 32'h004);
        bus.req = 4'b0000;
        serve(4, 32'd0, 2);
        tick(1);
        chk("t3_done", 32'(bus.done), 32'h4);
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_timeout", 32'(bus.timeout), 32'd0);

        // Zero byte count runs as one byte; req2 raised mid-gap is granted right after
        bus.req_number_of_bytes[0] = 8'd0;
        bus.req                    = 4'b0001;
        wait_grant(cyc);
        chk("t6_grant0", 32'(bus.grant), 32'h1);
        chk("t6_nb0", 32'(bus.i2c_number_of_bytes), 32'd1);
        bus.req = 4'b0000;
        serve(1, 32'h12345678, 0);
        tick(1);
        chk("t6_done0", 32'(bus.done), 32'h1);
        chk("t6_err0", 32'({bus.err, bus.timeout}), 32'd0);
        tick(50);
        bus.req_number_of_bytes[2] = 8'd2;
        bus.req                    = 4'b0100;
        wait_grant(cyc);
        chk("t6_grant2", 32'(bus.grant), 32'h4);
        chk("t6_gap_end", 32'(cyc), 32'd52);
        bus.req = 4'b0000;
        serve(2, 32'h0, 0);
        tick(1);
        chk("t6_done2", 32'(bus.done), 32'h4);

        // Watchdog: busy stuck high, no bytes counted
        bus.req_number_of_bytes[1] = 8'd2;
        bus.req                    = 4'b0010;
        wait_grant(cyc);
        chk("t4_grant", 32'(bus.grant), 32'h2);
        bus.req      = 4'b0000;
        bus.i2c_busy = 1'b1;
        tick(499);
        chk("t4_pre_ena", 32'(bus.i2c_ena), 32'd1);
        chk("t4_pre_to", 32'({bus.timeout, bus.done}), 32'd0);
        tick(1);
        chk("t4_ena", 32'(bus.i2c_ena), 32'd0);
        chk("t4_done", 32'(bus.done), 32'h2);
        chk("t4_to_err", 32'({bus.timeout, bus.err}), 32'h3);
        bus.i2c_busy = 1'b0;
        tick(1);
        chk("t4_done_pulse", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
